// File: rtl/sort4_seq_pkg.sv
// Shared encodings for the sort4 sequence source: generator modes, FSM states
// and the Galois LFSR feedback masks.
package sort4_seq_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_UP    = 2'd0;
  localparam logic [MODE_W-1:0] MODE_DOWN  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_LFSR  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_CONST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam logic [7:0]  LFSR_MASK_8  = 8'hB8;
  localparam logic [15:0] LFSR_MASK_16 = 16'hB400;

  // Right-shifting Galois feedback mask for a given register width.
  function automatic logic [31:0] lfsr_mask(input int unsigned width);
    case (width)
      8:       return 32'(LFSR_MASK_8);
      16:      return 32'(LFSR_MASK_16);
      default: return 32'(LFSR_MASK_8);
    endcase
  endfunction

endpackage

// File: rtl/seq_lfsr.sv
// Galois LFSR register for the sequence source; load restarts from the seed,
// enable advances one step.
module seq_lfsr
  import sort4_seq_pkg::*;
#(
  parameter int unsigned     width = 8,
  parameter logic [width-1:0] mask = width'(lfsr_mask(width))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [width-1:0] seed,
  output logic [width-1:0] next_c
);

  logic [width-1:0] lfsr_q;
  logic [width-1:0] seed_nz;

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  assign seed_nz = (seed == '0) ? width'(1) : seed;
  assign next_c  = (lfsr_q >> 1) ^ (lfsr_q[0] ? mask : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= seed_nz;
    end else if (load) begin
      lfsr_q <= seed_nz;
    end else if (enable) begin
      lfsr_q <= next_c;
    end
  end

endmodule

// File: rtl/sort4_sequence_source.sv
// Stimulus source for the sort4 sorter: framed deterministic element stream over
// valid/ready plus the expected maximum of each completed frame.
module sort4_sequence_source
  import sort4_seq_pkg::*;
#(
  parameter int unsigned data_width = 8,
  parameter int unsigned frame_len  = 4,
  parameter logic [31:0] lfsr_seed  = 32'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [7:0]            num_frames,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [data_width-1:0] frame_max,
  output logic                  frame_max_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned EW = (frame_len > 1) ? $clog2(frame_len) : 1;
  localparam logic [EW-1:0] ELEM_LAST = EW'(frame_len - 1);
  localparam logic [data_width-1:0] SEED_W  = data_width'(lfsr_seed);
  localparam logic [data_width-1:0] SEED_NZ = (SEED_W == '0) ? data_width'(1) : SEED_W;

  seq_state_e state_q, state_d;

  logic [1:0]            mode_q, mode_d;
  logic [7:0]            nfr_q, nfr_d;
  logic [EW-1:0]         elem_q, elem_d;
  logic [7:0]            frm_q, frm_d;
  logic [data_width-1:0] run_max_q, run_max_d;

  logic [data_width-1:0] out_data_d;
  logic                  out_valid_d;
  logic                  out_last_d;
  logic [data_width-1:0] frame_max_d;
  logic                  frame_max_valid_d;
  logic                  busy_d;
  logic                  done_d;

  logic                  lfsr_load;
  logic                  lfsr_en;
  logic [data_width-1:0] lfsr_next_c;

  logic [data_width-1:0] gen_start;
  logic [data_width-1:0] gen_next;
  logic [data_width-1:0] beat_max;
  logic [EW-1:0]         elem_nxt;
  logic                  xfer;

  seq_lfsr #(
    .width (data_width)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load),
    .enable (lfsr_en),
    .seed   (SEED_W),
    .next_c (lfsr_next_c)
  );

  assign xfer     = out_valid && out_ready;
  assign beat_max = (out_data > run_max_q) ? out_data : run_max_q;
  assign elem_nxt = (elem_q == ELEM_LAST) ? '0 : elem_q + EW'(1);

  // First generator value for the mode presented with start.
  always_comb begin
    gen_start = '0;
    case (mode)
      MODE_UP:    gen_start = '0;
      MODE_DOWN:  gen_start = '1;
      MODE_LFSR:  gen_start = SEED_NZ;
      MODE_CONST: gen_start = SEED_W;
      default:    gen_start = '0;
    endcase
  end

  // Generator value following the one currently on out_data.
  always_comb begin
    gen_next = out_data;
    case (mode_q)
      MODE_UP:    gen_next = out_data + data_width'(1);
      MODE_DOWN:  gen_next = out_data - data_width'(1);
      MODE_LFSR:  gen_next = lfsr_next_c;
      MODE_CONST: gen_next = SEED_W;
      default:    gen_next = out_data;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d           = state_q;
    mode_d            = mode_q;
    nfr_d             = nfr_q;
    elem_d            = elem_q;
    frm_d             = frm_q;
    run_max_d         = run_max_q;
    out_data_d        = out_data;
    out_valid_d       = out_valid;
    out_last_d        = out_last;
    frame_max_d       = frame_max;
    frame_max_valid_d = 1'b0;
    busy_d            = busy;
    done_d            = 1'b0;
    lfsr_load         = 1'b0;
    lfsr_en           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          mode_d    = mode;
          nfr_d     = num_frames;
          elem_d    = '0;
          frm_d     = '0;
          run_max_d = '0;
          lfsr_load = 1'b1;
          busy_d    = 1'b1;
          if (num_frames == 8'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = ST_SEND;
            out_valid_d = 1'b1;
            out_data_d  = gen_start;
            out_last_d  = (ELEM_LAST == '0);
          end
        end
      end

      ST_SEND: begin
        if (xfer) begin
          elem_d = elem_nxt;
          if (out_last) begin
            frame_max_d       = beat_max;
            frame_max_valid_d = 1'b1;
            run_max_d         = '0;
            frm_d             = frm_q + 8'd1;
          end else begin
            run_max_d = beat_max;
          end

          if (out_last && (frm_q == nfr_q - 8'd1)) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            out_data_d = gen_next;
            out_last_d = (elem_nxt == ELEM_LAST);
            lfsr_en    = (mode_q == MODE_LFSR);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      mode_q          <= MODE_UP;
      nfr_q           <= '0;
      elem_q          <= '0;
      frm_q           <= '0;
      run_max_q       <= '0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
      frame_max       <= '0;
      frame_max_valid <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      nfr_q           <= nfr_d;
      elem_q          <= elem_d;
      frm_q           <= frm_d;
      run_max_q       <= run_max_d;
      out_data        <= out_data_d;
      out_valid       <= out_valid_d;
      out_last        <= out_last_d;
      frame_max       <= frame_max_d;
      frame_max_valid <= frame_max_valid_d;
      busy            <= busy_d;
      done            <= done_d;
    end
  end

endmodule

// File: tb/tb_sort4_sequence_source.sv
// Scoreboard bench for sort4_sequence_source: a reference model queues expected
// beats and frame maxima per run; a monitor consumes them as the DUT delivers.
module tb_sort4_sequence_source;

  localparam int unsigned DW = 8;
  localparam int unsigned FL = 4;
  localparam logic [7:0] SEED = 8'hA5;

  logic          tb_clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [7:0]    num_frames;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic [DW-1:0] frame_max;
  logic          frame_max_valid;
  logic          busy;
  logic          done;

  sort4_sequence_source #(
    .data_width (DW),
    .frame_len  (FL),
    .lfsr_seed  (32'(SEED))
  ) dut (
    .clk             (tb_clk),
    .rst             (rst),
    .start           (start),
    .mode            (mode),
    .num_frames      (num_frames),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_last        (out_last),
    .out_ready       (out_ready),
    .frame_max       (frame_max),
    .frame_max_valid (frame_max_valid),
    .busy            (busy),
    .done            (done)
  );

  always #5 tb_clk = ~tb_clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       fin;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] fm_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int expect_done_at = -1;
  int expect_fmv_at = -1;
  int expect_valid_at = -1;
  int done_seen = 0;
  int beats_seen = 0;
  int ready_mode = 0;
  logic [7:0] last_fm = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: element i of a run is the i-th generator value; frames
  // are consecutive groups of FL elements.
  function automatic logic [7:0] gen_step(input int m, input logic [7:0] v);
    int x;
    x = int'(v);
    case (m)
      0:       x = (x + 1) % 256;
      1:       x = (x + 255) % 256;
      2:       x = (x / 2) ^ (((x % 2) == 1) ? 'hB8 : 0);
      default: x = int'(SEED);
    endcase
    return 8'(x);
  endfunction

  task automatic model_push(input int m, input int nf);
    logic [7:0] v;
    logic [7:0] mx;
    beat_t b;
    case (m)
      0:       v = 8'h00;
      1:       v = 8'hFF;
      default: v = SEED;
    endcase
    for (int f = 0; f < nf; f++) begin
      mx = 8'h00;
      for (int e = 0; e < int'(FL); e++) begin
        b.data = v;
        b.last = (e == int'(FL) - 1);
        b.fin  = (f == nf - 1) && (e == int'(FL) - 1);
        exp_q.push_back(b);
        if (v > mx) mx = v;
        v = gen_step(m, v);
      end
      fm_q.push_back(mx);
      last_fm = mx;
    end
  endtask

  // Downstream ready: 0 = always, 1 = alternating, 2 = random.
  initial begin
    forever begin
      @(posedge tb_clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: consumes expectations whenever the DUT presents something.
  initial begin
    beat_t b;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    prev_last  = 1'b0;
    forever begin
      @(negedge tb_clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (cyc == expect_valid_at) check("start_latency", 32'(out_valid), 32'd1);
        if (prev_stall) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(out_data), 32'(prev_data));
          check("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got data %0h, expected no beat (cycle %0d)", out_data, cyc);
          end else begin
            b = exp_q.pop_front();
            check("beat_data", 32'(out_data), 32'(b.data));
            check("beat_last", 32'(out_last), 32'(b.last));
            beats_seen++;
            if (b.fin)  expect_done_at = cyc + 1;
            if (b.last) expect_fmv_at  = cyc + 1;
          end
        end
        if (frame_max_valid || (cyc == expect_fmv_at)) begin
          check("fmv_timing", 32'(frame_max_valid), 32'(cyc == expect_fmv_at));
          if (frame_max_valid && fm_q.size() != 0) check("frame_max", 32'(frame_max), 32'(fm_q.pop_front()));
        end
        if (done || (cyc == expect_done_at)) begin
          check("done_timing", 32'(done), 32'(cyc == expect_done_at));
          if (done) done_seen++;
        end
        if (out_valid || done) check("busy_active", 32'(busy), 32'd1);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  task automatic issue_start(input int m, input int nf);
    @(posedge tb_clk);
    #1;
    mode       = 2'(m);
    num_frames = 8'(nf);
    start      = 1'b1;
    if (nf == 0) expect_done_at = cyc + 2;
    else         expect_valid_at = cyc + 2;
    @(posedge tb_clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input int m, input int nf, input int rm);
    int d0;
    ready_mode = rm;
    model_push(m, nf);
    d0 = done_seen;
    issue_start(m, nf);
    for (int i = 0; i < 3000 && done_seen == d0; i++) @(posedge tb_clk);
    if (done_seen == d0) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: got no done, expected done (mode %0d frames %0d)", m, nf);
    end
    @(posedge tb_clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(out_valid), 32'd0);
    if (nf > 0) check("frame_max_hold", 32'(frame_max), 32'(last_fm));
    exp_q.delete();
    fm_q.delete();
  endtask

  task automatic reset_mid_run();
    int b0;
    ready_mode = 0;
    model_push(0, 2);
    b0 = beats_seen;
    issue_start(0, 2);
    for (int i = 0; i < 100 && beats_seen < b0 + 2; i++) @(posedge tb_clk);
    if (beats_seen < b0 + 2) begin
      tests++;
      fails++;
      $display("FAIL reset_wait: got %0d beats, expected 2", beats_seen - b0);
    end
    #1;
    rst = 1'b1;
    exp_q.delete();
    fm_q.delete();
    expect_done_at  = -1;
    expect_fmv_at   = -1;
    expect_valid_at = -1;
    @(posedge tb_clk);
    #1;
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fmv", 32'(frame_max_valid), 32'd0);
    repeat (4) @(posedge tb_clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    mode       = 2'd0;
    num_frames = 8'd0;
    out_ready  = 1'b1;
    repeat (3) @(posedge tb_clk);
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_last", 32'(out_last), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_fmv", 32'(frame_max_valid), 32'd0);
    check("reset_frame_max", 32'(frame_max), 32'd0);
    rst = 1'b0;
    @(posedge tb_clk);
    #1;

    run(0, 2, 0);    // count up, free flowing
    run(0, 2, 1);    // count up, alternating ready
    run(1, 1, 0);    // count down
    run(0, 0, 0);    // zero frames
    reset_mid_run();
    run(0, 1, 0);    // restarts from 0 after reset
    run(0, 65, 2);   // 8-bit wrap across frames
    run(2, 1, 0);    // LFSR
    run(2, 3, 2);
    run(3, 2, 1);    // constant
    for (int k = 0; k < 8; k++) begin
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
